pc_fetch_unit: RTL and testbench

//   Program counter and instruction fetch sequencer: the stage directly upstream of the control unit.
//   - Holds the PC and fetches from instruction memory using a req/ack handshake.
//   - Presents the fetched instruction to the control unit and computes the next PC from the

---
 rtl/pc_fetch_unit_if.sv | 29 ++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
// Latency: purely a bundle of wires, no storage.
// Backpressure: the requester holds req/addr stable until ack is seen.
//
// Signals:
//   imem_req   - fetch request (requester -> memory)
//   imem_addr  - fetch address (requester -> memory)
//   imem_ack   - imem_rdata is valid this cycle (memory -> requester)
//   imem_rdata - fetched instruction word (memory -> requester)
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the control unit.
// Latency: 2 cycles per instruction with zero-wait memory (FETCH, EXEC), +1 per wait cycle.
// Backpressure: stalls in FETCH with req/addr held until imem_ack; ack outside FETCH ignored.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   PC_control      - next-PC select (0/other=PC+4, 1=J, 2=JR, 3=branch taken), used in EXEC
//   jump_target     - J target field, branch_offset - signed word offset, jr_target - rs data
//   imem            - instruction memory fetch port (master side)
//   instruction     - latched instruction word driving the control unit
//   instr_valid     - high for the single EXEC cycle
//   pc, pc_plus4    - current PC and PC+4
//   misalign_err    - sticky flag, set on a misaligned JR target (unit then halts)
//   retired_count   - committed instruction count, wraps
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             PC_control,
  input  logic [25:0]            jump_target,
  input  logic [15:0]            branch_offset,
  input  logic [31:0]            jr_target,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instruction,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   misalign_err,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = req_q;

  // Sign-extended word offset, added to the already-incremented PC.
  assign branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

  assign jr_misaligned = (PC_control == 4'd2) && (jr_target[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    case (PC_control)
      4'd1:    next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      4'd2:    next_pc = jr_target;
      4'd3:    next_pc = branch_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // req and instr_valid are registered copies of the state they belong to,
  // so they are set on the transition into FETCH / EXEC respectively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_VECTOR;
      req_q         <= 1'b0;
      instruction   <= 32'h0000_0000;
      instr_valid   <= 1'b0;
      misalign_err  <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            instruction <= imem.imem_rdata;
            state       <= EXEC;
            req_q       <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          instr_valid <= 1'b0;
          if (jr_misaligned) begin
            // Faulting JR does not commit: PC and count stay put.
            misalign_err <= 1'b1;
            state        <= HALT;
          end else begin
            pc            <= next_pc;
            retired_count <= retired_count + COUNT_WIDTH'(1);
            state         <= FETCH;
            req_q         <= 1'b1;
          end
        end
        default: begin
          // HALT: only reset leaves this state.
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int NV = 11;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  ctl;
    logic [25:0] jt;
    logic [15:0] bo;
    logic [31:0] jr;
    int          dly;
    int          gap;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] count;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_b = 1'b1;
  logic [3:0]  ctl = 4'd0;
  logic [25:0] jt = 26'd0;
  logic [15:0] bo = 16'd0;
  logic [31:0] jr = 32'd0;
  int          mode = 0;
  int          fi = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  vec_t vecs [NV];
  exp_t exp_q [$];

  logic [31:0] instruction, pc, pc_plus4;
  logic        instr_valid, misalign_err;
  logic [31:0] retired_count;

  logic [31:0] instruction_b, pc_b, pc_plus4_b;
  logic        instr_valid_b, misalign_err_b;
  logic [31:0] retired_count_b;

  pc_fetch_unit_if a_if ();
  pc_fetch_unit_if b_if ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .COUNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_control    (ctl),
    .jump_target   (jt),
    .branch_offset (bo),
    .jr_target     (jr),
    .imem          (a_if),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign_err  (misalign_err),
    .retired_count (retired_count)
  );

  // Second instance: reset vector at the top of the address space, zero-wait memory.
  assign b_if.imem_ack   = b_if.imem_req;
  assign b_if.imem_rdata = 32'h1234_5678;

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .COUNT_WIDTH(32)) dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .PC_control    (4'd0),
    .jump_target   (26'd0),
    .branch_offset (16'd0),
    .jr_target     (32'd0),
    .imem          (b_if),
    .instruction   (instruction_b),
    .instr_valid   (instr_valid_b),
    .pc            (pc_b),
    .pc_plus4      (pc_plus4_b),
    .misalign_err  (misalign_err_b),
    .retired_count (retired_count_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] instr_word(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Directed program: pc expected at fetch, PC_control and fields for its EXEC,
  // memory wait cycles, and expected cycle gap since the previous instr_valid.
  initial begin
    //           pc             ctl   jt        bo          jr             dly gap
    vecs[0]  = '{32'h0000_0000, 4'd0, 26'h0,    16'h0000, 32'h0,         0,  0};
    vecs[1]  = '{32'h0000_0004, 4'd0, 26'h0,    16'h0000, 32'h0,         0,  2};
    vecs[2]  = '{32'h0000_0008, 4'd0, 26'h0,    16'h0000, 32'h0,         0,  2};
    vecs[3]  = '{32'h0000_000C, 4'd0, 26'h0,    16'h0000, 32'h0,         0,  2};
    vecs[4]  = '{32'h0000_0010, 4'd3, 26'h0,    16'hFFFE, 32'h0,         0,  2};
    vecs[5]  = '{32'h0000_000C, 4'd0, 26'h0,    16'h0000, 32'h0,         0,  2};
    vecs[6]  = '{32'h0000_0010, 4'd3, 26'h0,    16'h0003, 32'h0,         0,  2};
    vecs[7]  = '{32'h0000_0020, 4'd2, 26'h0,    16'h0000, 32'h1000_0000, 0,  2};
    vecs[8]  = '{32'h1000_0000, 4'd1, 26'h40,   16'h0000, 32'h0,         0,  2};
    vecs[9]  = '{32'h1000_0100, 4'd7, 26'h0,    16'h0000, 32'h0,         2,  4};
    vecs[10] = '{32'h1000_0104, 4'd2, 26'h0,    16'h0000, 32'h0000_0102, 0,  2};
  end

  // Memory model and stimulus: answers fetches, drives the EXEC-time inputs,
  // and pushes the expected EXEC observation for each instruction handed over.
  always @(negedge clk) begin
    if (mode == 0) begin
      if (a_if.imem_req) begin
        if (fi < NV) begin
          chk("fetch_addr", a_if.imem_addr, vecs[fi].pc);
          if (wcnt == vecs[fi].dly) begin
            a_if.imem_ack   = 1'b1;
            a_if.imem_rdata = instr_word(fi);
            ctl = vecs[fi].ctl;
            jt  = vecs[fi].jt;
            bo  = vecs[fi].bo;
            jr  = vecs[fi].jr;
            exp_q.push_back('{vecs[fi].pc, instr_word(fi), 32'(fi), vecs[fi].gap});
            fi++;
            wcnt = 0;
          end else begin
            a_if.imem_ack = 1'b0;
            wcnt++;
          end
        end else begin
          chk("req_after_program", 32'(a_if.imem_req), 32'd0);
          a_if.imem_ack = 1'b0;
        end
      end else begin
        // Once the program is exhausted, raise stray acks that must be ignored.
        a_if.imem_ack   = (fi == NV);
        a_if.imem_rdata = 32'hDEAD_BEEF;
      end
    end else begin
      a_if.imem_ack   = 1'b0;
      a_if.imem_rdata = 32'hDEAD_BEEF;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (instr_valid && mode == 0) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("exec_pc", pc, e.pc);
        chk("exec_instruction", instruction, e.instr);
        chk("exec_retired_count", retired_count, e.count);
        chk("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
        if (e.gap > 0) chk("exec_gap_cycles", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  initial begin
    a_if.imem_ack   = 1'b0;
    a_if.imem_rdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(a_if.imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_count", retired_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_after_release", 32'(a_if.imem_req), 32'd1);

    // Run the program until the misaligned JR halts the unit.
    for (int c = 0; c < 300 && !misalign_err; c++) @(negedge clk);
    chk("halt_reached", 32'(misalign_err), 32'd1);
    begin
      int req_seen;
      int valid_seen;
      req_seen = 0;
      valid_seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (a_if.imem_req) req_seen++;
        if (instr_valid) valid_seen++;
      end
      chk("halt_req_cycles", 32'(req_seen), 32'd0);
      chk("halt_valid_cycles", 32'(valid_seen), 32'd0);
    end
    chk("halt_pc", pc, 32'h1000_0104);
    chk("halt_count", retired_count, 32'd10);
    chk("halt_instruction", instruction, instr_word(10));
    chk("halt_misalign", 32'(misalign_err), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Delayed fetch interrupted by reset.
    mode = 1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("wait_req", 32'(a_if.imem_req), 32'd1);
      chk("wait_addr", a_if.imem_addr, 32'h0);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      if (c < 2) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(a_if.imem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_count", retired_count, 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);

    // Wrap at the top of the address space.
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 0; c < 20 && !instr_valid_b; c++) @(negedge clk);
    chk("wrap_first_valid", 32'(instr_valid_b), 32'd1);
    chk("wrap_first_pc", pc_b, 32'hFFFF_FFFC);
    chk("wrap_first_plus4", pc_plus4_b, 32'h0);
    chk("wrap_first_instr", instruction_b, 32'h1234_5678);
    @(negedge clk);
    for (int c = 0; c < 20 && !instr_valid_b; c++) @(negedge clk);
    chk("wrap_second_valid", 32'(instr_valid_b), 32'd1);
    chk("wrap_second_pc", pc_b, 32'h0);
    chk("wrap_second_count", retired_count_b, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
